// File: rtl/bp_be_dcache_pkg.sv
// Package bp_be_dcache_pkg: shared types for the dcache data-memory arbiter.
// Holds the requester select encoding, the grant bundle and a saturating
// increment helper used by the optional performance counters
// (BP_BE_DCACHE_DMEM_ARB_PERF_EN).
package bp_be_dcache_pkg;

    // Bank count the grant bundle is sized for; the arbiter's ways_p must match.
    localparam int unsigned dcache_ways_lp = 8;

    typedef enum logic [1:0] {
        e_dmem_req_none = 2'd0,
        e_dmem_req_lce  = 2'd1,
        e_dmem_req_ld   = 2'd2,
        e_dmem_req_wb   = 2'd3
    } bp_be_dcache_dmem_req_e;

    typedef struct packed {
        logic                      v;
        logic                      we;
        bp_be_dcache_dmem_req_e    sel;
        logic [dcache_ways_lp-1:0] bank_mask;
    } bp_be_dcache_dmem_grant_s;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/bp_be_dcache_dmem_starve_ctr.sv
// Saturating starvation counter for the write-buffer drain requester.
// limit_o reports that the count reaches the limit at the coming edge, so
// the arbiter can raise boost in step with the counter itself.
module bp_be_dcache_dmem_starve_ctr #(
    parameter int unsigned limit_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic inc_i,
    input  logic clear_i,
    output logic limit_o
);

    localparam int unsigned width_lp = $clog2(limit_p + 1);
    localparam logic [width_lp-1:0] limit_lp = width_lp'(limit_p);

    logic [width_lp-1:0] count_r;
    logic [width_lp-1:0] count_n;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_n = count_r;
        if (clear_i) begin
            count_n = '0;
        end else if (inc_i && (count_r != limit_lp)) begin
            count_n = count_r + 1'b1;
        end
    end

    assign limit_o = (count_n == limit_lp);

    // Count register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else begin
            count_r <= count_n;
        end
    end

endmodule

// File: rtl/bp_be_dcache_dmem_arbiter.sv
// Dcache data-memory arbiter: grants the single-ported data memory to one of
// LCE, TL-stage load or write-buffer drain each cycle. LCE bursts hold a lock;
// a starved or full write buffer is boosted above loads.
// Optional counters are built when BP_BE_DCACHE_DMEM_ARB_PERF_EN is defined.
module bp_be_dcache_dmem_arbiter
    import bp_be_dcache_pkg::*;
#(
    parameter int unsigned ways_p         = dcache_ways_lp,
    parameter int unsigned starve_limit_p = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,

    input  logic              lce_v_i,
    input  logic              lce_we_i,
    input  logic              lce_last_i,
    input  logic [ways_p-1:0] lce_bank_mask_i,
    output logic              lce_ready_o,

    input  logic              ld_v_i,
    input  logic [ways_p-1:0] ld_bank_mask_i,
    output logic              ld_ready_o,

    input  logic              wb_v_i,
    input  logic              wb_full_i,
    input  logic [ways_p-1:0] wb_bank_mask_i,
    output logic              wb_ready_o,

    output logic              dmem_v_o,
    output logic              dmem_we_o,
    output logic [1:0]        dmem_sel_o,
    output logic [ways_p-1:0] dmem_bank_mask_o
`ifdef BP_BE_DCACHE_DMEM_ARB_PERF_EN
    ,
    output logic [3:0][31:0]  perf_cnt_o,
    output logic [31:0]       perf_boost_cnt_o
`endif
);

    logic                     lock_r;
    logic                     boost_r;
    logic                     boost_n;
    logic                     starve_limit;
    bp_be_dcache_dmem_req_e   winner;
    bp_be_dcache_dmem_grant_s grant;

    bp_be_dcache_dmem_starve_ctr #(
        .limit_p (starve_limit_p)
    ) starve_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (wb_v_i & ~wb_ready_o),
        .clear_i   (~wb_v_i | wb_ready_o),
        .limit_o   (starve_limit)
    );

    // Priority select: LCE always first; a lock admits LCE only; boost swaps
    // wbuf ahead of loads. Held idle while reset is asserted.
    always_comb begin
        winner = e_dmem_req_none;
        if (!reset_n_i) begin
            winner = e_dmem_req_none;
        end else if (lce_v_i) begin
            winner = e_dmem_req_lce;
        end else if (lock_r) begin
            winner = e_dmem_req_none;
        end else if ((boost_r | wb_full_i) && wb_v_i) begin
            winner = e_dmem_req_wb;
        end else if (ld_v_i) begin
            winner = e_dmem_req_ld;
        end else if (wb_v_i) begin
            winner = e_dmem_req_wb;
        end
    end

    // Decode the winner into handshakes and the data-memory grant bundle.
    always_comb begin
        grant       = '0;
        grant.sel   = winner;
        lce_ready_o = 1'b0;
        ld_ready_o  = 1'b0;
        wb_ready_o  = 1'b0;
        unique case (winner)
            e_dmem_req_lce: begin
                lce_ready_o     = 1'b1;
                grant.v         = 1'b1;
                grant.we        = lce_we_i;
                grant.bank_mask = dcache_ways_lp'(lce_bank_mask_i);
            end
            e_dmem_req_ld: begin
                ld_ready_o      = 1'b1;
                grant.v         = 1'b1;
                grant.we        = 1'b0;
                grant.bank_mask = dcache_ways_lp'(ld_bank_mask_i);
            end
            e_dmem_req_wb: begin
                wb_ready_o      = 1'b1;
                grant.v         = 1'b1;
                grant.we        = 1'b1;
                grant.bank_mask = dcache_ways_lp'(wb_bank_mask_i);
            end
            default: ;
        endcase
    end

    assign dmem_v_o         = grant.v;
    assign dmem_we_o        = grant.we;
    assign dmem_sel_o       = grant.sel;
    assign dmem_bank_mask_o = ways_p'(grant.bank_mask);

    // Boost next state: a full wbuf only counts once the lock has released.
    always_comb begin
        boost_n = boost_r;
        if (wb_ready_o) begin
            boost_n = 1'b0;
        end else if (starve_limit || (wb_full_i && !lock_r)) begin
            boost_n = 1'b1;
        end
    end

    // Lock follows LCE beats; boost register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_r  <= 1'b0;
            boost_r <= 1'b0;
        end else begin
            if (lce_ready_o) begin
                lock_r <= ~lce_last_i;
            end
            boost_r <= boost_n;
        end
    end

`ifdef BP_BE_DCACHE_DMEM_ARB_PERF_EN
    logic [3:0][31:0] perf_cnt_r;
    logic [31:0]      perf_boost_cnt_r;
    logic             bubble;

    assign bubble = reset_n_i & lock_r & ~lce_v_i;

    // Saturating event counters: grants per requester, lock bubbles, boost entries.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_cnt_r       <= '0;
            perf_boost_cnt_r <= '0;
        end else begin
            perf_cnt_r[0]    <= sat_inc32(perf_cnt_r[0], lce_ready_o);
            perf_cnt_r[1]    <= sat_inc32(perf_cnt_r[1], ld_ready_o);
            perf_cnt_r[2]    <= sat_inc32(perf_cnt_r[2], wb_ready_o);
            perf_cnt_r[3]    <= sat_inc32(perf_cnt_r[3], bubble);
            perf_boost_cnt_r <= sat_inc32(perf_boost_cnt_r, boost_n & ~boost_r);
        end
    end

    assign perf_cnt_o       = perf_cnt_r;
    assign perf_boost_cnt_o = perf_boost_cnt_r;
`endif

    a_wb_mask_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        wb_v_i |-> $onehot(wb_bank_mask_i));

    a_single_grant: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0({lce_ready_o, ld_ready_o, wb_ready_o}));

endmodule

// File: tb/tb_bp_be_dcache_dmem_arbiter.sv
// Scoreboard bench for bp_be_dcache_dmem_arbiter: each driven cycle pushes
// its hand-computed expected grant; a negedge monitor pops and compares.
module tb_bp_be_dcache_dmem_arbiter;
    import bp_be_dcache_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lce_v, lce_we, lce_last, lce_ready;
    logic [7:0] lce_mask;
    logic       ld_v, ld_ready;
    logic [7:0] ld_mask;
    logic       wb_v, wb_full, wb_ready;
    logic [7:0] wb_mask;
    logic       dmem_v, dmem_we;
    logic [1:0] dmem_sel;
    logic [7:0] dmem_mask;
`ifdef BP_BE_DCACHE_DMEM_ARB_PERF_EN
    logic [3:0][31:0] perf_cnt;
    logic [31:0]      perf_boost_cnt;
`endif

    always #5 clk = ~clk;

    bp_be_dcache_dmem_arbiter #(
        .ways_p         (8),
        .starve_limit_p (4)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .lce_v_i          (lce_v),
        .lce_we_i         (lce_we),
        .lce_last_i       (lce_last),
        .lce_bank_mask_i  (lce_mask),
        .lce_ready_o      (lce_ready),
        .ld_v_i           (ld_v),
        .ld_bank_mask_i   (ld_mask),
        .ld_ready_o       (ld_ready),
        .wb_v_i           (wb_v),
        .wb_full_i        (wb_full),
        .wb_bank_mask_i   (wb_mask),
        .wb_ready_o       (wb_ready),
        .dmem_v_o         (dmem_v),
        .dmem_we_o        (dmem_we),
        .dmem_sel_o       (dmem_sel),
        .dmem_bank_mask_o (dmem_mask)
`ifdef BP_BE_DCACHE_DMEM_ARB_PERF_EN
        ,
        .perf_cnt_o       (perf_cnt),
        .perf_boost_cnt_o (perf_boost_cnt)
`endif
    );

    // {lce_ready, ld_ready, wb_ready}, dmem_v, dmem_we, dmem_sel, dmem_bank_mask
    typedef struct packed {
        logic [2:0] rdy;
        logic       v;
        logic       we;
        logic [1:0] sel;
        logic [7:0] mask;
    } exp_t;

    localparam logic [7:0] LM  = 8'h0F;
    localparam logic [7:0] LM2 = 8'hF0;
    localparam logic [7:0] DM  = 8'h10;
    localparam logic [7:0] WM  = 8'h04;

    localparam exp_t E_NONE = '{rdy: 3'b000, v: 1'b0, we: 1'b0, sel: 2'd0, mask: 8'h00};
    localparam exp_t E_LD   = '{rdy: 3'b010, v: 1'b1, we: 1'b0, sel: 2'd2, mask: DM};
    localparam exp_t E_WB   = '{rdy: 3'b001, v: 1'b1, we: 1'b1, sel: 2'd3, mask: WM};
    localparam exp_t E_LCEW = '{rdy: 3'b100, v: 1'b1, we: 1'b1, sel: 2'd1, mask: LM};
    localparam exp_t E_LCER = '{rdy: 3'b100, v: 1'b1, we: 1'b0, sel: 2'd1, mask: LM2};

    exp_t        exp_q[$];
    int unsigned id_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned vec_id   = 0;

    // Drive one cycle of inputs and queue the expected response for it.
    task automatic step(input logic rst, input logic lv, input logic lwe, input logic llast,
                        input logic [7:0] lm, input logic dv, input logic wv, input logic wf,
                        input exp_t e);
        reset_n  = rst;
        lce_v    = lv;
        lce_we   = lwe;
        lce_last = llast;
        lce_mask = lm;
        ld_v     = dv;
        ld_mask  = DM;
        wb_v     = wv;
        wb_full  = wf;
        wb_mask  = WM;
        exp_q.push_back(e);
        id_q.push_back(vec_id);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented grant against the oldest expectation.
    always @(negedge clk) begin
        exp_t        e;
        exp_t        act;
        int unsigned id;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            id  = id_q.pop_front();
            act = '{rdy: {lce_ready, ld_ready, wb_ready}, v: dmem_v, we: dmem_we,
                    sel: dmem_sel, mask: dmem_mask};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got rdy=%b v=%b we=%b sel=%0d mask=%h, want rdy=%b v=%b we=%b sel=%0d mask=%h",
                         id, act.rdy, act.v, act.we, act.sel, act.mask,
                         e.rdy, e.v, e.we, e.sel, e.mask);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        {lce_v, lce_we, lce_last, ld_v, wb_v, wb_full} = '0;
        lce_mask = '0;
        ld_mask  = '0;
        wb_mask  = '0;
        @(posedge clk);
        #1;

        // reset state with every request asserted
        step(0, 1, 1, 1, LM,  1, 1, 1, E_NONE);
        step(0, 1, 1, 1, LM,  1, 1, 1, E_NONE);
        // mid-burst reset
        step(1, 1, 1, 0, LM,  1, 0, 0, E_LCEW);
        step(1, 0, 0, 0, LM,  1, 0, 0, E_NONE);
        step(0, 1, 1, 0, LM,  1, 0, 0, E_NONE);
        step(1, 0, 0, 0, LM,  1, 0, 0, E_LD);
        // all valid, LCE wins; we follows lce_we; drop LCE -> load
        step(1, 1, 0, 1, LM2, 1, 1, 0, E_LCER);
        step(1, 1, 1, 1, LM,  1, 1, 0, E_LCEW);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 0, 0, E_LD);
        step(1, 0, 0, 0, LM,  0, 0, 0, E_NONE);
        // 4-beat burst with a gap after beat 2, load held
        step(1, 1, 1, 0, LM,  1, 0, 0, E_LCEW);
        step(1, 1, 1, 0, LM,  1, 0, 0, E_LCEW);
        step(1, 0, 1, 0, LM,  1, 0, 0, E_NONE);
        step(1, 1, 1, 0, LM,  1, 0, 0, E_LCEW);
        step(1, 1, 1, 1, LM,  1, 0, 0, E_LCEW);
        step(1, 0, 0, 0, LM,  1, 0, 0, E_LD);
        // starvation: 4 load grants, then wbuf, then load again
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_WB);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 0, 0, E_LD);
        // full wbuf: immediate wb grant; LCE still wins; boost lingers to next wb
        step(1, 0, 0, 0, LM,  1, 1, 1, E_WB);
        step(1, 1, 0, 1, LM2, 1, 1, 1, E_LCER);
        step(1, 0, 0, 0, LM,  0, 0, 0, E_NONE);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_WB);
        step(1, 0, 0, 0, LM,  1, 1, 0, E_LD);
        step(1, 0, 0, 0, LM,  1, 0, 0, E_LD);
        // full rising while locked has no effect until release
        step(1, 1, 1, 0, LM,  1, 1, 0, E_LCEW);
        step(1, 0, 1, 0, LM,  1, 1, 1, E_NONE);
        step(1, 1, 1, 1, LM,  1, 1, 1, E_LCEW);
        step(1, 0, 0, 0, LM,  1, 1, 1, E_WB);
        step(1, 0, 0, 0, LM,  0, 0, 0, E_NONE);

`ifdef BP_BE_DCACHE_DMEM_ARB_PERF_EN
        step(0, 0, 0, 0, LM,  0, 0, 0, E_NONE);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, LM, 1, 0, 0, E_LD);
        for (int i = 0; i < 3; i++)  step(1, 0, 0, 0, LM, 0, 1, 0, E_WB);
        step(1, 1, 1, 0, LM,  0, 0, 0, E_LCEW);
        step(1, 0, 0, 0, LM,  0, 0, 0, E_NONE);
        step(1, 0, 0, 0, LM,  0, 0, 0, E_NONE);
        step(1, 1, 1, 1, LM,  0, 0, 0, E_LCEW);
        step(1, 0, 0, 0, LM,  0, 0, 0, E_NONE);
        @(negedge clk);
        n_checks++;
        if (perf_cnt !== {32'd2, 32'd3, 32'd10, 32'd2}) begin
            n_fail++;
            $display("FAIL perf_cnt: got lce=%0d ld=%0d wb=%0d bubble=%0d, want 2 10 3 2",
                     perf_cnt[0], perf_cnt[1], perf_cnt[2], perf_cnt[3]);
        end
        n_checks++;
        if (perf_boost_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_boost: got %0d, want 0", perf_boost_cnt);
        end
`endif

        // bounded drain of the scoreboard
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
